// File: rtl/cm_ram_sdp_be_pipe.sv
// ---------------------------------------------------------------------------
// cm_ram_sdp_be_pipe
// Simple dual-port RAM on one clock: write port A with per-byte enables and
// read port B with 1- or 2-cycle latency. Read data is qualified by dob_vld.
// BYPASS selects what a same-address, same-edge read returns: old contents (0)
// or the contents merged with the in-flight write (1).
//
// Ports
//   clk     : clock, all logic on posedge
//   rst     : synchronous active-high reset (clears pipeline, not the array)
//   ena     : write-port enable
//   wea     : write strobe; write happens when ena & wea
//   bea     : byte enables, bea[i] covers dia[i*BYTE_W +: BYTE_W]
//   addra   : write address
//   dia     : write data
//   enb     : read request, one per cycle while high
//   addrb   : read address
//   dob     : read data, holds when no read completes
//   dob_vld : one-cycle pulse per completed read
// ---------------------------------------------------------------------------
module cm_ram_sdp_be_pipe #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned SIZE     = 10,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned BYPASS   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      wea,
    input  logic [WIDTH/BYTE_W-1:0]   bea,
    input  logic [SIZE-1:0]           addra,
    input  logic [WIDTH-1:0]          dia,
    input  logic                      enb,
    input  logic [SIZE-1:0]           addrb,
    output logic [WIDTH-1:0]          dob,
    output logic                      dob_vld
);

    localparam int unsigned NUM_BE = WIDTH / BYTE_W;
    localparam int unsigned DEPTH  = 2 ** SIZE;

    if ((WIDTH % BYTE_W) != 0) begin : g_bad_width
        $error("cm_ram_sdp_be_pipe: WIDTH must be a multiple of BYTE_W");
    end

    logic [WIDTH-1:0] ram [DEPTH];

    logic             wr_c;
    logic             rd_c;
    logic [WIDTH-1:0] rd_word_c;

    // Requests seen during reset are dropped.
    assign wr_c = ena & wea & ~rst;
    assign rd_c = enb & ~rst;

    // Byte-masked write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            for (int i = 0; i < NUM_BE; i++) begin
                if (bea[i]) begin
                    ram[addra][i*BYTE_W +: BYTE_W] <= dia[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read word: array contents, optionally merged with a colliding write.
    always_comb begin
        rd_word_c = ram[addrb];
        if ((BYPASS != 0) && wr_c && (addra == addrb)) begin
            for (int i = 0; i < NUM_BE; i++) begin
                if (bea[i]) begin
                    rd_word_c[i*BYTE_W +: BYTE_W] = dia[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    if (READ_LAT == 1) begin : g_lat1
        // Single stage: capture straight into the output register.
        always_ff @(posedge clk) begin
            if (rst) begin
                dob     <= '0;
                dob_vld <= 1'b0;
            end else begin
                dob_vld <= rd_c;
                if (rd_c) begin
                    dob <= rd_word_c;
                end
            end
        end
    end else if (READ_LAT == 2) begin : g_lat2
        logic [WIDTH-1:0] s1_data;
        logic             s1_vld;

        // Data is frozen in stage 1, so later writes cannot alter it.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_data <= '0;
                s1_vld  <= 1'b0;
                dob     <= '0;
                dob_vld <= 1'b0;
            end else begin
                s1_vld  <= rd_c;
                if (rd_c) begin
                    s1_data <= rd_word_c;
                end
                dob_vld <= s1_vld;
                if (s1_vld) begin
                    dob <= s1_data;
                end
            end
        end
    end else begin : g_bad_lat
        $error("cm_ram_sdp_be_pipe: READ_LAT must be 1 or 2");
        assign dob     = '0;
        assign dob_vld = 1'b0;
    end

endmodule

// File: tb/tb_cm_ram_sdp_be_pipe.sv
// ---------------------------------------------------------------------------
// tb_cm_ram_sdp_be_pipe
// Four instances (READ_LAT 1/2 x BYPASS 0/1) share one stimulus stream and are
// compared every cycle against a word-array memory model with a queue of
// pending read completions per instance.
// ---------------------------------------------------------------------------
module tb_cm_ram_sdp_be_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SIZE   = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NUM_BE = WIDTH / BYTE_W;
    localparam int unsigned DEPTH  = 2 ** SIZE;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              wea;
    logic [NUM_BE-1:0] bea;
    logic [SIZE-1:0]   addra;
    logic [WIDTH-1:0]  dia;
    logic              enb;
    logic [SIZE-1:0]   addrb;

    logic [WIDTH-1:0]  dob_a     [4];
    logic              dob_vld_a [4];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    logic [31:0] mem    [DEPTH];
    pend_t       q      [4][$];
    logic [31:0] last_d [4];

    always #5 clk = ~clk;

    cm_ram_sdp_be_pipe #(.WIDTH(WIDTH), .SIZE(SIZE), .BYTE_W(BYTE_W), .READ_LAT(1), .BYPASS(0)) u_l1b0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .dob(dob_a[0]), .dob_vld(dob_vld_a[0]));
    cm_ram_sdp_be_pipe #(.WIDTH(WIDTH), .SIZE(SIZE), .BYTE_W(BYTE_W), .READ_LAT(1), .BYPASS(1)) u_l1b1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .dob(dob_a[1]), .dob_vld(dob_vld_a[1]));
    cm_ram_sdp_be_pipe #(.WIDTH(WIDTH), .SIZE(SIZE), .BYTE_W(BYTE_W), .READ_LAT(2), .BYPASS(0)) u_l2b0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .dob(dob_a[2]), .dob_vld(dob_vld_a[2]));
    cm_ram_sdp_be_pipe #(.WIDTH(WIDTH), .SIZE(SIZE), .BYTE_W(BYTE_W), .READ_LAT(2), .BYPASS(1)) u_l2b1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .dob(dob_a[3]), .dob_vld(dob_vld_a[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%08h exp=%08h", tag, cyc, got, exp);
        end
    endtask

    // Byte-wise merge of new data into an old word under a byte mask.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    // One clock: drive inputs, update the model at the edge, check all instances.
    task automatic tick(input logic r, input logic ea, input logic we, input logic [3:0] be,
                        input logic [3:0] aa, input logic [31:0] d,
                        input logic eb, input logic [3:0] ab);
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic        coll;
        logic [31:0] exp_v;
        @(negedge clk);
        rst = r; ena = ea; wea = we; bea = be; addra = aa; dia = d; enb = eb; addrb = ab;
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                last_d[k] = 32'h0;
            end
        end else begin
            old_w = mem[ab];
            coll  = ea && we && (aa == ab);
            new_w = coll ? merge(old_w, d, be) : old_w;
            if (eb) begin
                for (int k = 0; k < 4; k++) begin
                    pend_t p;
                    p.due  = cyc + ((k < 2) ? 0 : 1);
                    p.data = (k % 2 == 1) ? new_w : old_w;
                    q[k].push_back(p);
                end
            end
            if (ea && we) mem[aa] = merge(mem[aa], d, be);
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_v = 32'h0;
            if (q[k].size() > 0 && q[k][0].due == cyc) begin
                exp_v     = 32'h1;
                last_d[k] = q[k][0].data;
                void'(q[k].pop_front());
            end
            chk($sformatf("vld[%0d]", k), 32'(dob_vld_a[k]), exp_v);
            chk($sformatf("dob[%0d]", k), dob_a[k], last_d[k]);
        end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        tick(1'b0, 1'b1, 1'b1, be, a, d, 1'b0, 4'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a);
    endtask

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) mem[a] = 32'h0;
        for (int k = 0; k < 4; k++) last_d[k] = 32'h0;
        rst = 1'b1; ena = 1'b0; wea = 1'b0; bea = '0; addra = '0; dia = '0; enb = 1'b0; addrb = '0;

        // Reset, then define every word so the model and the array agree.
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        for (int a = 0; a < int'(DEPTH); a++) wr(4'(a), 32'h0, 4'hF);

        // Full write then read.
        wr(4'd3, 32'hA5A5_1234, 4'hF);
        rd(4'd3);
        chk("t1_l1", dob_a[0], 32'hA5A5_1234);
        idle();
        chk("t1_l2", dob_a[2], 32'hA5A5_1234);

        // Partial write, then a bea=0 no-op write.
        wr(4'd5, 32'h1111_1111, 4'hF);
        wr(4'd5, 32'hAABB_CCDD, 4'b0101);
        rd(4'd5);
        chk("t2_part", dob_a[0], 32'h11BB_11DD);
        wr(4'd5, 32'h5555_5555, 4'h0);
        rd(4'd5);
        chk("t2_noop", dob_a[0], 32'h11BB_11DD);
        idle();

        // Same-edge collision.
        wr(4'd7, 32'h0, 4'hF);
        tick(1'b0, 1'b1, 1'b1, 4'b0011, 4'd7, 32'hFFFF_FFFF, 1'b1, 4'd7);
        chk("t3_b0_l1", dob_a[0], 32'h0000_0000);
        chk("t3_b1_l1", dob_a[1], 32'h0000_FFFF);
        rd(4'd7);
        chk("t3_b0_l2", dob_a[2], 32'h0000_0000);
        chk("t3_b1_l2", dob_a[3], 32'h0000_FFFF);
        idle();
        chk("t3_next", dob_a[2], 32'h0000_FFFF);

        // Back-to-back reads of the whole array.
        for (int a = 0; a < int'(DEPTH); a++) wr(4'(a), 32'(a) * 32'h0101_0101, 4'hF);
        for (int a = 0; a < int'(DEPTH); a++) rd(4'(a));
        idle();

        // Read followed by reset: the 2-cycle read is dropped.
        rd(4'd2);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        chk("t5_vld", 32'(dob_vld_a[2]), 32'h0);
        chk("t5_dob", dob_a[2], 32'h0);
        rd(4'd2);
        idle();
        chk("t5_pres", dob_a[2], 32'h0202_0202);

        // Idle hold and write-only cycles.
        for (int i = 0; i < 10; i++) idle();
        wr(4'd9, 32'hDEAD_BEEF, 4'hF);
        idle();

        // Randomized traffic over the small address space (collisions frequent).
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(0, 63) == 0),
                 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 4'($urandom));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
